fetch_stage: RTL and testbench

//  Instruction-fetch stage of the RV32I core: owns the program counter, drives the

---
 rtl/fetch_stage.sv | 96 +++++++++
 tb/tb_fetch_stage.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the instruction memory address and
// registers the fetched word into IF/ID. Handles stall, redirect and EBREAK halt.
module fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR  = 32'h0000_0013,
    parameter logic [31:0] HALT_INSTR = 32'h0010_0073
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rd,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        if_id_valid,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_pc_plus4,
    output logic        halted
);

    // Handshake: stall=1 means decode did not take IF/ID this cycle, so IF/ID
    // and PC hold; redirect=1 is a one-cycle request that wins over stall.
    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

    state_t      state, state_next;
    logic [31:0] pc, pc_next;
    logic        valid_next;
    logic [31:0] instr_next, ifpc_next, ifpc4_next;
    logic [31:0] pc_plus4;

    assign pc_plus4  = pc + 32'd4;
    assign imem_addr = pc;
    assign halted    = (state == HALT);

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= RUN;
            pc             <= RESET_PC;
            if_id_valid    <= 1'b0;
            if_id_instr    <= NOP_INSTR;
            if_id_pc       <= 32'd0;
            if_id_pc_plus4 <= 32'd0;
        end else begin
            state          <= state_next;
            pc             <= pc_next;
            if_id_valid    <= valid_next;
            if_id_instr    <= instr_next;
            if_id_pc       <= ifpc_next;
            if_id_pc_plus4 <= ifpc4_next;
        end
    end

    always_comb begin
        state_next = state;
        pc_next    = pc;
        valid_next = if_id_valid;
        instr_next = if_id_instr;
        ifpc_next  = if_id_pc;
        ifpc4_next = if_id_pc_plus4;
        case (state)
            HALT: begin
                // Redirect is ignored; a stalled EBREAK stays visible until decode takes it.
                if (!stall) begin
                    valid_next = 1'b0;
                    instr_next = NOP_INSTR;
                    ifpc_next  = 32'd0;
                    ifpc4_next = 32'd0;
                end
            end
            default: begin
                if (redirect) begin
                    pc_next    = {redirect_pc[31:2], 2'b00};
                    valid_next = 1'b0;
                    instr_next = NOP_INSTR;
                    ifpc_next  = 32'd0;
                    ifpc4_next = 32'd0;
                end else if (!stall) begin
                    valid_next = 1'b1;
                    instr_next = imem_rd;
                    ifpc_next  = pc;
                    ifpc4_next = pc_plus4;
                    if (imem_rd == HALT_INSTR) begin
                        state_next = HALT;
                    end else begin
                        pc_next = pc_plus4;
                    end
                end
            end
        endcase
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios then random stall/redirect/reset
// traffic, compared every cycle against a behavioural fetch model.
module tb_fetch_stage;

    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [31:0] EBRK = 32'h0010_0073;

    logic        clk = 1'b0;
    logic        reset, stall, redirect;
    logic [31:0] redirect_pc;
    logic [31:0] imem_addr, imem_rd;
    logic        if_id_valid, halted;
    logic [31:0] if_id_instr, if_id_pc, if_id_pc_plus4;

    logic [31:0] imem [256];

    int n_checks = 0;
    int n_pass   = 0;

    // model state
    logic [31:0] m_pc, m_instr, m_ifpc, m_ifpc4;
    logic        m_valid, m_halted;

    always #5 clk = ~clk;

    assign imem_rd = imem[imem_addr[9:2]];

    fetch_stage dut (
        .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_rd(imem_rd),
        .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
        .if_id_valid(if_id_valid), .if_id_instr(if_id_instr), .if_id_pc(if_id_pc),
        .if_id_pc_plus4(if_id_pc_plus4), .halted(halted)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic bubble();
        m_valid = 1'b0; m_instr = NOP; m_ifpc = 32'd0; m_ifpc4 = 32'd0;
    endtask

    // Advance the model by one clock from the currently driven inputs, then compare.
    task automatic step();
        logic [31:0] w;
        if (reset) begin
            m_pc = 32'd0; m_halted = 1'b0; bubble();
        end else if (m_halted) begin
            if (!stall) bubble();
        end else if (redirect) begin
            m_pc = redirect_pc & ~32'd3; bubble();
        end else if (!stall) begin
            w = imem[m_pc[9:2]];
            m_valid = 1'b1; m_instr = w; m_ifpc = m_pc; m_ifpc4 = m_pc + 32'd4;
            if (w == EBRK) m_halted = 1'b1;
            else m_pc = m_pc + 32'd4;
        end
        @(posedge clk);
        #1;
        check("imem_addr", imem_addr, m_pc);
        check("if_id_valid", {31'd0, if_id_valid}, {31'd0, m_valid});
        check("if_id_instr", if_id_instr, m_instr);
        check("if_id_pc", if_id_pc, m_ifpc);
        check("if_id_pc_plus4", if_id_pc_plus4, m_ifpc4);
        check("halted", {31'd0, halted}, {31'd0, m_halted});
    endtask

    initial begin
        for (int i = 0; i < 256; i++) imem[i] = $urandom() | 32'h0000_0100;
        imem[0] = 32'h0010_0093; imem[1] = 32'h0020_0113; imem[2] = 32'h0020_91b3;
        imem[3] = 32'h2222_2237; imem[4] = EBRK;
        imem[255] = 32'h0000_0033;
        reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'd0;

        // 1: reset and first fetches
        step(); step();
        reset = 1'b0;
        check("reset_addr", imem_addr, 32'd0);
        check("reset_valid", {31'd0, if_id_valid}, 32'd0);
        check("reset_instr", if_id_instr, NOP);
        step();
        check("first_instr", if_id_instr, 32'h0010_0093);
        check("first_addr", imem_addr, 32'd4);
        step();
        check("second_pc4", if_id_pc_plus4, 32'd8);

        // 2: stall holds PC and IF/ID
        stall = 1'b1;
        step(); step(); step();
        check("stall_addr", imem_addr, 32'd8);
        check("stall_instr", if_id_instr, 32'h0020_0113);
        stall = 1'b0;
        step();
        check("unstall_instr", if_id_instr, 32'h0020_91b3);

        // 3: redirect with unaligned target
        redirect = 1'b1; redirect_pc = 32'h0000_000E;
        step();
        redirect = 1'b0;
        check("redir_addr", imem_addr, 32'h0000_000C);
        check("redir_instr", if_id_instr, NOP);
        step();
        check("redir_fetch", if_id_instr, 32'h2222_2237);

        // 4: EBREAK halts, redirect ignored afterwards
        step();
        check("halt_flag", {31'd0, halted}, 32'd1);
        check("halt_instr", if_id_instr, EBRK);
        step();
        check("halt_bubble", {31'd0, if_id_valid}, 32'd0);
        redirect = 1'b1; redirect_pc = 32'd0;
        step();
        redirect = 1'b0;
        check("halt_redir_ignored", imem_addr, 32'h0000_0010);

        // 5: redirect in the EBREAK cycle wins over halt
        reset = 1'b1; step(); reset = 1'b0;
        step(); step(); step(); step();
        redirect = 1'b1; redirect_pc = 32'h0000_0020;
        step();
        redirect = 1'b0;
        check("redir_over_halt", {31'd0, halted}, 32'd0);
        check("redir_over_halt_addr", imem_addr, 32'h0000_0020);

        // 6: PC wrap, then reset during stall
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        step();
        redirect = 1'b0;
        step();
        check("wrap_addr", imem_addr, 32'd0);
        check("wrap_pc4", if_id_pc_plus4, 32'd0);
        stall = 1'b1;
        step();
        reset = 1'b1;
        step();
        reset = 1'b0; stall = 1'b0;
        check("reset_in_stall", {31'd0, if_id_valid}, 32'd0);

        // random traffic with a few EBREKs scattered in memory
        imem[40] = EBRK; imem[90] = EBRK; imem[200] = EBRK;
        for (int c = 0; c < 600; c++) begin
            reset       = ($urandom_range(0, 40) == 0);
            stall       = ($urandom_range(0, 3) == 0);
            redirect    = ($urandom_range(0, 7) == 0);
            redirect_pc = ($urandom_range(0, 15) == 0) ? $urandom() : 32'($urandom_range(0, 1023));
            step();
        end
        reset = 1'b0; stall = 1'b0; redirect = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
